// File: rtl/button_debounce_tick.sv
// Button synchroniser, four-state debouncer with rise/fall strobes, and tick divider.
// Optional TICK_SYNC_EN: a debounced press re-phases the tick divider.
module button_debounce_tick #(
   parameter int unsigned CLK_HZ      = 50_000_000,
   parameter int unsigned DEBOUNCE_MS = 20,
   parameter int unsigned TICK_HZ     = 4
) (
   input  logic clk_in,
   input  logic rst_in,
   input  logic button_raw,
   output logic btn_level,
   output logic btn_rise,
   output logic btn_fall,
   output logic tick_4hz
);

   localparam int unsigned DB_CYC   = CLK_HZ / 1000 * DEBOUNCE_MS;
   localparam int unsigned TICK_DIV = CLK_HZ / TICK_HZ;
   localparam int unsigned DB_W     = $clog2(DB_CYC);
   localparam int unsigned DIV_W    = $clog2(TICK_DIV);
   localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DB_CYC - 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

   if (DB_CYC < 2) begin : g_bad_db
      $error("button_debounce_tick: debounce window must be at least 2 cycles");
   end
   if (TICK_DIV < 2 || TICK_DIV * TICK_HZ != CLK_HZ) begin : g_bad_div
      $error("button_debounce_tick: tick divider must be an exact integer >= 2");
   end

   typedef enum logic [1:0] {
      IDLE,
      CONFIRM_HI,
      HELD,
      CONFIRM_LO
   } state_t;

   state_t            state, state_nxt;
   logic              sync1, sync2;
   logic [DB_W-1:0]   db_cnt, db_cnt_nxt;
   logic              level_nxt, rise_nxt, fall_nxt;
   logic [DIV_W-1:0]  div_cnt;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         sync1     <= 1'b0;
         sync2     <= 1'b0;
         state     <= IDLE;
         db_cnt    <= '0;
         btn_level <= 1'b0;
         btn_rise  <= 1'b0;
         btn_fall  <= 1'b0;
      end else begin
         sync1     <= button_raw;
         sync2     <= sync1;
         state     <= state_nxt;
         db_cnt    <= db_cnt_nxt;
         btn_level <= level_nxt;
         btn_rise  <= rise_nxt;
         btn_fall  <= fall_nxt;
      end
   end

   // Any disagreement with the current level during a confirm drops back, so every
   // bounce restarts the full window.
   always_comb begin
      state_nxt  = state;
      db_cnt_nxt = db_cnt;
      level_nxt  = btn_level;
      rise_nxt   = 1'b0;
      fall_nxt   = 1'b0;
      case (state)
         IDLE: begin
            if (sync2) begin
               state_nxt  = CONFIRM_HI;
               db_cnt_nxt = '0;
            end
         end
         CONFIRM_HI: begin
            if (!sync2) begin
               state_nxt = IDLE;
            end else if (db_cnt == DB_LAST) begin
               state_nxt = HELD;
               level_nxt = 1'b1;
               rise_nxt  = 1'b1;
            end else begin
               db_cnt_nxt = db_cnt + DB_W'(1);
            end
         end
         HELD: begin
            if (!sync2) begin
               state_nxt  = CONFIRM_LO;
               db_cnt_nxt = '0;
            end
         end
         CONFIRM_LO: begin
            if (sync2) begin
               state_nxt = HELD;
            end else if (db_cnt == DB_LAST) begin
               state_nxt = IDLE;
               level_nxt = 1'b0;
               fall_nxt  = 1'b1;
            end else begin
               db_cnt_nxt = db_cnt + DB_W'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         div_cnt  <= '0;
         tick_4hz <= 1'b0;
      end else begin
         if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
         end else begin
            div_cnt <= div_cnt + DIV_W'(1);
         end
         tick_4hz <= (div_cnt == DIV_LAST);
`ifdef TICK_SYNC_EN
         // Restart the tick period on the press so a hold is counted from btn_rise.
         if (rise_nxt) begin
            div_cnt  <= '0;
            tick_4hz <= 1'b0;
         end
`endif
      end
   end

endmodule

// File: tb/tb_button_debounce_tick.sv
// Scoreboard bench for button_debounce_tick: a run-length debounce model pushes
// expected outputs each edge; a monitor pops and compares on the falling edge.
module tb_button_debounce_tick;

   localparam int DB_CYC   = 5;
   localparam int TICK_DIV = 250;

   logic clk_in = 1'b0;
   logic rst_in;
   logic button_raw;
   logic btn_level, btn_rise, btn_fall, tick_4hz;

   int checks = 0;
   int errors = 0;

   logic [3:0] exp_q[$];
   int edge_n   = 0;
   int anchor   = 0;
   int run      = 0;
   logic m_lvl  = 1'b0;
   logic m_s1   = 1'b0;
   logic m_s2   = 1'b0;
   int rise_cnt = 0;
   int fall_cnt = 0;
   int tick_cnt = 0;

   button_debounce_tick #(
      .CLK_HZ(1000),
      .DEBOUNCE_MS(5),
      .TICK_HZ(4)
   ) dut (
      .clk_in(clk_in),
      .rst_in(rst_in),
      .button_raw(button_raw),
      .btn_level(btn_level),
      .btn_rise(btn_rise),
      .btn_fall(btn_fall),
      .tick_4hz(tick_4hz)
   );

   always #5 clk_in = ~clk_in;

   task automatic step(input logic r, input logic b);
      rst_in     = r;
      button_raw = b;
      @(posedge clk_in);
      #1;
   endtask

   task automatic check_count(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d required %0d", name, act, req);
      end
   endtask

   task automatic clear_window();
      rise_cnt = 0;
      fall_cnt = 0;
      tick_cnt = 0;
   endtask

   initial begin
      rst_in     = 1'b1;
      button_raw = 1'b0;

      fork
         // Reference model: the level flips once the synchronised input has disagreed
         // with it for DB_CYC+1 consecutive edges; ticks every TICK_DIV edges from the
         // last anchor (reset, or a press when the divider is re-phased).
         forever begin
            logic rise, fall, tick, s;
            @(posedge clk_in);
            edge_n++;
            rise = 1'b0;
            fall = 1'b0;
            tick = 1'b0;
            if (rst_in) begin
               m_s1   = 1'b0;
               m_s2   = 1'b0;
               m_lvl  = 1'b0;
               run    = 0;
               anchor = edge_n;
            end else begin
               s = m_s2;
               if (s != m_lvl) begin
                  run++;
                  if (run == DB_CYC + 1) begin
                     m_lvl = s;
                     run   = 0;
                     rise  = s;
                     fall  = ~s;
                  end
               end else begin
                  run = 0;
               end
               m_s2 = m_s1;
               m_s1 = button_raw;
`ifdef TICK_SYNC_EN
               if (rise) anchor = edge_n;
`endif
               tick = (edge_n > anchor) && ((edge_n - anchor) % TICK_DIV == 0);
            end
            exp_q.push_back({m_lvl, rise, fall, tick});
         end

         forever begin
            logic [3:0] exp, act;
            @(negedge clk_in);
            if (exp_q.size() > 0) begin
               exp = exp_q.pop_front();
               act = {btn_level, btn_rise, btn_fall, tick_4hz};
               rise_cnt += int'(btn_rise);
               fall_cnt += int'(btn_fall);
               tick_cnt += int'(tick_4hz);
               checks++;
               if (act != exp) begin
                  errors++;
                  $display("FAIL outputs edge %0d: got lvl/rise/fall/tick=%b required %b",
                           edge_n, act, exp);
               end
            end
         end
      join_none

      // Reset with the button held high.
      repeat (3) step(1'b1, 1'b1);
      repeat (10) step(1'b0, 1'b0);

      // Clean press, then release.
      clear_window();
      repeat (30) step(1'b0, 1'b1);
      repeat (30) step(1'b0, 1'b0);
      @(negedge clk_in); #1;
      check_count("clean_rise_count", rise_cnt, 1);
      check_count("clean_fall_count", fall_cnt, 1);

      // Short glitch is rejected.
      clear_window();
      repeat (4) step(1'b0, 1'b1);
      repeat (20) step(1'b0, 1'b0);
      @(negedge clk_in); #1;
      check_count("glitch_rise_count", rise_cnt, 0);

      // Reset in the middle of a confirm.
      clear_window();
      repeat (5) step(1'b0, 1'b1);
      step(1'b1, 1'b1);
      check_count("reset_abort_rise", rise_cnt, 0);
      repeat (20) step(1'b0, 1'b1);
      repeat (20) step(1'b0, 1'b0);

      // Bounce, then settle high.
      clear_window();
      for (int i = 0; i < 10; i++) step(1'b0, (i % 2 == 0) ? 1'b1 : 1'b0);
      repeat (20) step(1'b0, 1'b1);
      @(negedge clk_in); #1;
      check_count("bounce_rise_count", rise_cnt, 1);
      check_count("bounce_fall_count", fall_cnt, 0);
      repeat (20) step(1'b0, 1'b0);

      // Free-running tick over 1000 cycles.
      step(1'b1, 1'b0);
      clear_window();
      repeat (1000) step(1'b0, 1'b0);
      @(negedge clk_in); #1;
      check_count("tick_count_1000", tick_cnt, 4);

      // Press landing mid tick period.
      step(1'b1, 1'b0);
      repeat (92) step(1'b0, 1'b0);
      repeat (300) step(1'b0, 1'b1);
      repeat (30) step(1'b0, 1'b0);

      // Random bouncy segments with occasional resets.
      repeat (150) begin
         int len;
         logic val;
         len = int'($urandom_range(1, 12));
         val = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 49) == 0) step(1'b1, val);
         repeat (len) step(1'b0, val);
      end
      repeat (20) step(1'b0, 1'b0);
      @(negedge clk_in); #1;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
